// File: rtl/me_msad_tracker.sv
// Block minimum-SAD tracker: per-batch column minimum (stage 1) feeding a running block minimum (stage 2).
// Optional centre-candidate bias is enabled by defining ME_MSAD_CENTER_BIAS_EN.
module me_msad_tracker #(
  parameter int CANDS         = 16,
  parameter int ROWS          = 16,
  parameter int SAD_BIT_WIDTH = 14,
  parameter int CENTER_BIAS   = 16,
  localparam int COL_W = (CANDS > 1) ? $clog2(CANDS) : 1,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CANDS*SAD_BIT_WIDTH-1:0]   sad_batch_i,
  input  logic                             batch_valid_i,
  input  logic                             block_start_i,
  output logic                             in_ready_o,
  output logic [SAD_BIT_WIDTH-1:0]         msad_o,
  output logic [COL_W-1:0]                 msad_col_o,
  output logic [ROW_W-1:0]                 msad_row_o,
  output logic                             msad_valid_o,
  input  logic                             out_ready_i,
  output logic                             err_o,
  output logic [1:0]                       dbg_state_o
);

  // Input handshake: a batch is taken on any cycle where batch_valid_i && in_ready_o.
  // Output handshake: the result is held while msad_valid_o is high until out_ready_i is seen.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  state_t state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic in_ready_q, in_ready_d;
  logic valid_q, valid_d;
  logic err_q, err_d;

  logic accept;
  logic s1_load;
  logic [ROW_W-1:0] batch_row;

  logic [SAD_BIT_WIDTH-1:0] cand [CANDS];
  logic [SAD_BIT_WIDTH-1:0] min_val;
  logic [COL_W-1:0]         min_col;

  logic                     s1_valid_q;
  logic                     s1_first_q;
  logic [SAD_BIT_WIDTH-1:0] s1_val_q;
  logic [COL_W-1:0]         s1_col_q;
  logic [ROW_W-1:0]         s1_row_q;

  logic [SAD_BIT_WIDTH-1:0] msad_q;
  logic [COL_W-1:0]         msad_col_q;
  logic [ROW_W-1:0]         msad_row_q;

  assign accept    = batch_valid_i && in_ready_q;
  assign s1_load   = accept && (block_start_i || (state_q == ACCUM));
  assign batch_row = block_start_i ? '0 : row_q;

`ifdef ME_MSAD_CENTER_BIAS_EN
  localparam logic [SAD_BIT_WIDTH-1:0] BIAS_V     = SAD_BIT_WIDTH'(CENTER_BIAS);
  localparam logic [ROW_W-1:0]         CENTER_ROW = ROW_W'(ROWS / 2);
`endif

  always_comb begin
    for (int c = 0; c < CANDS; c++) begin
      cand[c] = sad_batch_i[c*SAD_BIT_WIDTH +: SAD_BIT_WIDTH];
`ifdef ME_MSAD_CENTER_BIAS_EN
      // Centre of the search window is favoured; saturate at zero rather than wrap.
      if ((c == CANDS / 2) && (batch_row == CENTER_ROW)) begin
        cand[c] = (cand[c] > BIAS_V) ? (cand[c] - BIAS_V) : '0;
      end
`endif
    end
  end

  // Strict less-than keeps the lowest column on ties.
  always_comb begin
    min_val = cand[0];
    min_col = '0;
    for (int c = 1; c < CANDS; c++) begin
      if (cand[c] < min_val) begin
        min_val = cand[c];
        min_col = COL_W'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_val_q   <= '0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
    end else begin
      s1_valid_q <= s1_load;
      if (s1_load) begin
        s1_first_q <= (batch_row == '0);
        s1_val_q   <= min_val;
        s1_col_q   <= min_col;
        s1_row_q   <= batch_row;
      end
    end
  end

  // Row 0 always loads, so a restarted block discards whatever was accumulated before it.
  always_ff @(posedge clk) begin
    if (rst) begin
      msad_q     <= '0;
      msad_col_q <= '0;
      msad_row_q <= '0;
    end else if (s1_valid_q && (s1_first_q || (s1_val_q < msad_q))) begin
      msad_q     <= s1_val_q;
      msad_col_q <= s1_col_q;
      msad_row_q <= s1_row_q;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    err_d   = err_q;
    if (batch_valid_i && !in_ready_q) begin
      err_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (block_start_i) begin
            state_d = ACCUM;
            row_d   = ROW_ONE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if (block_start_i) begin
            row_d = ROW_ONE;
            err_d = 1'b1;
          end else if (row_q == LAST_ROW) begin
            state_d = DRAIN;
            row_d   = '0;
          end else begin
            row_d = row_q + ROW_ONE;
          end
        end
      end
      DRAIN: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        row_d   = '0;
      end
    endcase
    in_ready_d = (state_d == IDLE) || (state_d == ACCUM);
    valid_d    = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      in_ready_q <= 1'b1;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      in_ready_q <= in_ready_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign msad_valid_o = valid_q;
  assign err_o        = err_q;
  assign msad_o       = msad_q;
  assign msad_col_o   = msad_col_q;
  assign msad_row_o   = msad_row_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_me_msad_tracker.sv
// Directed bench for me_msad_tracker at default parameters; expected results are hand-computed.
module tb_me_msad_tracker;

  localparam int CANDS = 16;
  localparam int ROWS  = 16;
  localparam int W     = 14;
  localparam int COL_W = 4;
  localparam int ROW_W = 4;
  localparam int RES_W = W + COL_W + ROW_W;

  logic               clk = 1'b0;
  logic               rst;
  logic [CANDS*W-1:0] sad_batch;
  logic               batch_valid;
  logic               block_start;
  logic               in_ready;
  logic [W-1:0]       msad;
  logic [COL_W-1:0]   msad_col;
  logic [ROW_W-1:0]   msad_row;
  logic               msad_valid;
  logic               out_ready;
  logic               err;
  logic [1:0]         dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [RES_W-1:0] exp_q[$];
  int               sp_row[4];
  int               sp_col[4];
  logic [W-1:0]     sp_val[4];

  me_msad_tracker dut (
    .clk           (clk),
    .rst           (rst),
    .sad_batch_i   (sad_batch),
    .batch_valid_i (batch_valid),
    .block_start_i (block_start),
    .in_ready_o    (in_ready),
    .msad_o        (msad),
    .msad_col_o    (msad_col),
    .msad_row_o    (msad_row),
    .msad_valid_o  (msad_valid),
    .out_ready_i   (out_ready),
    .err_o         (err),
    .dbg_state_o   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_sp();
    for (int k = 0; k < 4; k++) begin
      sp_row[k] = -1;
      sp_col[k] = -1;
      sp_val[k] = '0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    batch_valid = 1'b0;
    block_start = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One batch driven for one cycle; valid is dropped again before the next edge.
  task automatic send_batch(input logic start, input int row, input logic [W-1:0] fill);
    for (int c = 0; c < CANDS; c++) begin
      logic [W-1:0] v;
      v = fill;
      for (int k = 0; k < 4; k++) begin
        if (sp_row[k] == row && sp_col[k] == c) v = sp_val[k];
      end
      sad_batch[c*W +: W] = v;
    end
    block_start = start;
    batch_valid = 1'b1;
    @(negedge clk);
    batch_valid = 1'b0;
    block_start = 1'b0;
  endtask

  task automatic send_rows(input int n, input logic [W-1:0] fill);
    for (int r = 0; r < n; r++) begin
      send_batch(r == 0, r, fill);
    end
  endtask

  // Called right after the last batch: one DRAIN cycle, then the held result.
  task automatic expect_result(input string tag);
    logic [RES_W-1:0] e;
    check_eq({tag, "_drain_valid"}, msad_valid, 1'b0);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_exp_q_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_valid"}, msad_valid, 1'b1);
      check_eq({tag, "_msad"}, msad, e[RES_W-1 -: W]);
      check_eq({tag, "_col"}, msad_col, e[ROW_W +: COL_W]);
      check_eq({tag, "_row"}, msad_row, e[ROW_W-1:0]);
      check_eq({tag, "_in_ready_hold"}, in_ready, 1'b0);
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_valid_after_hs"}, msad_valid, 1'b0);
    check_eq({tag, "_in_ready_after_hs"}, in_ready, 1'b1);
    check_eq({tag, "_state_after_hs"}, dbg_state, 2'd0);
  endtask

  initial begin
    rst = 1'b1;
    sad_batch = '0;
    batch_valid = 1'b0;
    block_start = 1'b0;
    out_ready = 1'b0;
    clear_sp();
    @(negedge clk);
    apply_reset();

    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_valid", msad_valid, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_msad", msad, 0);
    check_eq("rst_col", msad_col, 0);
    check_eq("rst_row", msad_row, 0);

    // Single minimum in the middle of the block; checks T+2 latency.
    clear_sp();
    sp_row[0] = 5; sp_col[0] = 9; sp_val[0] = 14'd37;
    exp_q.push_back({14'd37, 4'd9, 4'd5});
    send_rows(ROWS, 14'd500);
    expect_result("single");
    check_eq("single_err", err, 1'b0);
    handshake("single");

    // All equal: column and row ties resolve to the lowest index; result held without out_ready.
    clear_sp();
`ifdef ME_MSAD_CENTER_BIAS_EN
    exp_q.push_back({14'd84, 4'd8, 4'd8});
`else
    exp_q.push_back({14'd100, 4'd0, 4'd0});
`endif
    send_rows(ROWS, 14'd100);
    expect_result("ties");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("ties_hold_valid", msad_valid, 1'b1);
      check_eq("ties_hold_in_ready", in_ready, 1'b0);
`ifdef ME_MSAD_CENTER_BIAS_EN
      check_eq("ties_hold_msad", msad, 14'd84);
`else
      check_eq("ties_hold_msad", msad, 14'd100);
`endif
    end
    handshake("ties");

    // Restart on row 7; the smaller value in the discarded part must not survive.
    clear_sp();
    sp_row[0] = 2; sp_col[0] = 4; sp_val[0] = 14'd5;
    send_rows(7, 14'd500);
    check_eq("restart_err_before", err, 1'b0);
    clear_sp();
    sp_row[0] = 3; sp_col[0] = 2; sp_val[0] = 14'd12;
    exp_q.push_back({14'd12, 4'd2, 4'd3});
    send_rows(ROWS, 14'd500);
    expect_result("restart");
    check_eq("restart_err", err, 1'b1);
    handshake("restart");

    // Reset mid-block clears the sticky error and the partial block.
    clear_sp();
    send_rows(10, 14'd300);
    check_eq("mid_state_accum", dbg_state, 2'd1);
    apply_reset();
    check_eq("mid_rst_valid", msad_valid, 1'b0);
    check_eq("mid_rst_err", err, 1'b0);
    check_eq("mid_rst_in_ready", in_ready, 1'b1);
    check_eq("mid_rst_state", dbg_state, 2'd0);
    clear_sp();
    sp_row[0] = 0;  sp_col[0] = 0;  sp_val[0] = 14'd16383;
    sp_row[1] = 11; sp_col[1] = 15; sp_val[1] = 14'd7;
    sp_row[2] = 11; sp_col[2] = 6;  sp_val[2] = 14'd7;
    sp_row[3] = 12; sp_col[3] = 0;  sp_val[3] = 14'd7;
    exp_q.push_back({14'd7, 4'd6, 4'd11});
    send_rows(ROWS, 14'd900);
    expect_result("fresh");
    handshake("fresh");

    // Protocol errors: stray batch in IDLE, batch while holding a result.
    clear_sp();
    send_batch(1'b0, 0, 14'd1);
    check_eq("idle_drop_err", err, 1'b1);
    check_eq("idle_drop_state", dbg_state, 2'd0);
    check_eq("idle_drop_in_ready", in_ready, 1'b1);
    apply_reset();
    sp_row[0] = 4; sp_col[0] = 4; sp_val[0] = 14'd200;
    exp_q.push_back({14'd200, 4'd4, 4'd4});
    send_rows(ROWS, 14'd500);
    expect_result("holdbusy");
    sp_row[0] = 0; sp_col[0] = 0; sp_val[0] = 14'd1;
    send_batch(1'b1, 0, 14'd2);
    check_eq("holdbusy_err", err, 1'b1);
    check_eq("holdbusy_valid", msad_valid, 1'b1);
    @(negedge clk);
    check_eq("holdbusy_msad", msad, 14'd200);
    check_eq("holdbusy_col", msad_col, 4'd4);
    handshake("holdbusy");

    // Centre candidate (row 8, col 8) against a plain 30 elsewhere.
    apply_reset();
    clear_sp();
    sp_row[0] = 8; sp_col[0] = 8;  sp_val[0] = 14'd40;
    sp_row[1] = 3; sp_col[1] = 11; sp_val[1] = 14'd30;
`ifdef ME_MSAD_CENTER_BIAS_EN
    exp_q.push_back({14'd24, 4'd8, 4'd8});
`else
    exp_q.push_back({14'd30, 4'd11, 4'd3});
`endif
    send_rows(ROWS, 14'd500);
    expect_result("center");
    handshake("center");
    check_eq("final_exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
